// File: rtl/stream_demux_1to4.sv
// rtl/stream_demux_1to4.sv - 1:4 stream demultiplexer with a one-entry holding register per channel
// Optional per-channel transfer counters are built when STREAM_DEMUX_CNT_EN is defined.
module stream_demux_1to4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef STREAM_DEMUX_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2,
  output logic [7:0]       cnt3
`endif
);

  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       valid_q;
  logic             accept;
  logic [3:0]       wr;
  logic [3:0]       rd;

  // A selected slot can take a new word when it is empty or draining this cycle.
  assign in_ready = !valid_q[s] || out_ready[s];
  assign accept   = in_valid && in_ready;

  always_comb begin
    wr = 4'b0000;
    if (accept) wr[s] = 1'b1;
  end

  assign rd = valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 4'b0000;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr[i]) begin
          data_q[i]  <= in_data;
          valid_q[i] <= 1'b1;
        end else if (rd[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];

`ifdef STREAM_DEMUX_CNT_EN
  logic [7:0] cnt_q [4];

  // Clear wins over a same-cycle increment; 8-bit add wraps 255 -> 0.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr[i]) cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_stream_demux_1to4.sv
// tb/tb_stream_demux_1to4.sv - scoreboard bench for stream_demux_1to4
// Counter checks are compiled in when STREAM_DEMUX_CNT_EN is defined.
module tb_stream_demux_1to4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] s;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
`ifdef STREAM_DEMUX_CNT_EN
  logic       cnt_clr = 1'b0;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;
  logic [7:0] m_cnt [4];
`endif

  int tests = 0;
  int fails = 0;
  logic       armed = 1'b0;
  logic [7:0] exp_q [4][$];

  always #5 clk = ~clk;

  stream_demux_1to4 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .s(s), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef STREAM_DEMUX_CNT_EN
    , .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dout(input int i);
    case (i)
      0: return out_data0;
      1: return out_data1;
      2: return out_data2;
      default: return out_data3;
    endcase
  endfunction

`ifdef STREAM_DEMUX_CNT_EN
  function automatic logic [7:0] dcnt(input int i);
    case (i)
      0: return cnt0;
      1: return cnt1;
      2: return cnt2;
      default: return cnt3;
    endcase
  endfunction
`endif

  // Monitor: compare against the scoreboard, then advance the model for the next edge.
  always @(negedge clk) begin
    logic [3:0] m_valid;
    logic       exp_rdy;
    for (int i = 0; i < 4; i++) m_valid[i] = (exp_q[i].size() != 0);
    exp_rdy = !m_valid[s] || out_ready[s];
    if (armed) begin
      check("mon_out_valid", {28'd0, out_valid}, {28'd0, m_valid});
      check("mon_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      for (int i = 0; i < 4; i++)
        if (m_valid[i]) check($sformatf("mon_out_data%0d", i), {24'd0, dout(i)}, {24'd0, exp_q[i][0]});
`ifdef STREAM_DEMUX_CNT_EN
      for (int i = 0; i < 4; i++)
        check($sformatf("mon_cnt%0d", i), {24'd0, dcnt(i)}, {24'd0, m_cnt[i]});
`endif
    end
    if (rst) begin
      for (int i = 0; i < 4; i++) exp_q[i].delete();
`ifdef STREAM_DEMUX_CNT_EN
      for (int i = 0; i < 4; i++) m_cnt[i] = 8'd0;
`endif
      armed = 1'b1;
    end else if (armed) begin
      for (int i = 0; i < 4; i++)
        if (m_valid[i] && out_ready[i]) void'(exp_q[i].pop_front());
      if (in_valid && exp_rdy) exp_q[s].push_back(in_data);
`ifdef STREAM_DEMUX_CNT_EN
      if (cnt_clr) begin
        for (int i = 0; i < 4; i++) m_cnt[i] = 8'd0;
      end else if (in_valid && exp_rdy) begin
        m_cnt[s] = m_cnt[s] + 8'd1;
      end
`endif
    end
  end

  task automatic drive(input logic r, input logic [1:0] sel, input logic [7:0] d,
                       input logic v, input logic [3:0] rdy);
    rst = r; s = sel; in_data = d; in_valid = v; out_ready = rdy;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; s = 2'd0; in_data = 8'd0; in_valid = 1'b0; out_ready = 4'b0000;
    drive(1, 0, 8'h00, 0, 4'b0000);
    drive(1, 3, 8'hFF, 1, 4'b1111);
    check("reset_out_valid", {28'd0, out_valid}, 32'h0);
    check("reset_out_data0", {24'd0, out_data0}, 32'h0);
    check("reset_out_data3", {24'd0, out_data3}, 32'h0);
    check("reset_in_ready", {31'd0, in_ready}, 32'h1);
`ifdef STREAM_DEMUX_CNT_EN
    check("reset_cnt0", {24'd0, cnt0}, 32'h0);
`endif

    // single word to channel 2, then idle with s moving and in_valid low
    drive(0, 2, 8'hA5, 1, 4'b0000);
    check("route_ch2_valid", {28'd0, out_valid}, 32'h4);
    check("route_ch2_data", {24'd0, out_data2}, 32'hA5);
    drive(0, 1, 8'h77, 0, 4'b0000);
    drive(0, 2, 8'h78, 0, 4'b0000);
    check("idle_no_write_data2", {24'd0, out_data2}, 32'hA5);

    // channel 1 full and stalled, then released with a simultaneous write
    drive(0, 1, 8'h11, 1, 4'b0000);
    check("ch1_fill_valid", {28'd0, out_valid}, 32'h6);
    s = 2'd1; in_data = 8'h22; in_valid = 1'b1; out_ready = 4'b0000; #1;
    check("ch1_full_in_ready", {31'd0, in_ready}, 32'h0);
    drive(0, 1, 8'h22, 1, 4'b0000);
    check("ch1_stall_data", {24'd0, out_data1}, 32'h11);
    s = 2'd1; in_data = 8'h22; in_valid = 1'b1; out_ready = 4'b0010; #1;
    check("ch1_drain_in_ready", {31'd0, in_ready}, 32'h1);
    drive(0, 1, 8'h22, 1, 4'b0010);
    check("ch1_replace_valid", {28'd0, out_valid}, 32'h6);
    check("ch1_replace_data", {24'd0, out_data1}, 32'h22);
    drive(0, 0, 8'h00, 0, 4'b1111);
    check("drain_all_valid", {28'd0, out_valid}, 32'h0);

    // channel 0 stalled does not block channel 3
    drive(0, 0, 8'h33, 1, 4'b0000);
    s = 2'd3; in_data = 8'h44; in_valid = 1'b1; out_ready = 4'b0000; #1;
    check("ch3_in_ready_ch0_full", {31'd0, in_ready}, 32'h1);
    drive(0, 3, 8'h44, 1, 4'b0000);
    check("ch0_ch3_valid", {28'd0, out_valid}, 32'h9);
    check("ch0_held_data", {24'd0, out_data0}, 32'h33);
    check("ch3_data", {24'd0, out_data3}, 32'h44);
    drive(0, 3, 8'h00, 0, 4'b1111);

    // full-throughput round robin, data 1..8
    for (int k = 1; k <= 8; k++) begin
      drive(0, 2'((k - 1) % 4), 8'(k), 1, 4'b1111);
      check($sformatf("rr_valid_%0d", k), {28'd0, out_valid}, 32'(1 << ((k - 1) % 4)));
      check($sformatf("rr_data_%0d", k), {24'd0, dout((k - 1) % 4)}, 32'(k));
    end
    drive(0, 0, 8'h00, 0, 4'b1111);
    check("rr_drained", {28'd0, out_valid}, 32'h0);

    // reset coincident with a write to a full channel
    drive(0, 2, 8'h55, 1, 4'b0000);
    drive(1, 2, 8'h66, 1, 4'b0000);
    check("rst_override_valid", {28'd0, out_valid}, 32'h0);
    check("rst_override_data2", {24'd0, out_data2}, 32'h0);
    drive(0, 0, 8'h00, 0, 4'b0000);

`ifdef STREAM_DEMUX_CNT_EN
    drive(0, 1, 8'h01, 1, 4'b1111);
    check("cnt1_one", {24'd0, cnt1}, 32'h1);
    for (int k = 0; k < 256; k++) drive(0, 0, 8'(k), 1, 4'b1111);
    check("cnt0_wrap", {24'd0, cnt0}, 32'h0);
    drive(0, 0, 8'hAB, 1, 4'b1111);
    check("cnt0_after_wrap", {24'd0, cnt0}, 32'h1);
    cnt_clr = 1'b1;
    drive(0, 0, 8'hCD, 1, 4'b1111);
    cnt_clr = 1'b0;
    check("cnt0_clr_priority", {24'd0, cnt0}, 32'h0);
    check("cnt1_cleared", {24'd0, cnt1}, 32'h0);
`endif

    drive(0, 0, 8'h00, 0, 4'b1111);
    drive(0, 0, 8'h00, 0, 4'b1111);
    for (int i = 0; i < 4; i++)
      check($sformatf("no_leftover_ch%0d", i), exp_q[i].size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_demux_1to4.md
STREAM_DEMUX_1TO4 -- requirements
Module: stream_demux_1to4

Interface
REQ-001 Parameter WIDTH, default 8, data width of the input and of each output channel.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 s  input  2  channel select; s=0..3 routes to channel 0..3.
REQ-005 in_data  input  WIDTH  input payload.
REQ-006 in_valid  input  1  source offers in_data.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out_data0..out_data3  output  WIDTH each  per-channel registered payload.
REQ-009 out_valid  output  4  bit i: channel i holds a valid word.
REQ-010 out_ready  input  4  bit i: sink i accepts out_data<i> this cycle.
REQ-011 cnt_clr  input  1  synchronous clear of the transfer counters (STREAM_DEMUX_CNT_EN only).
REQ-012 cnt0..cnt3  output  8 each  per-channel accepted-transfer counters (STREAM_DEMUX_CNT_EN only).

Function
REQ-013 Each channel i SHALL have a one-entry holding register (data + valid flag).
REQ-014 in_ready SHALL be combinational: in_ready = !out_valid[s] || out_ready[s].
REQ-015 An input transfer SHALL occur when in_valid && in_ready; in_data is written to channel s and out_valid[s] is 1 on the next cycle (latency 1 cycle).
REQ-016 An output transfer on channel i SHALL occur when out_valid[i] && out_ready[i].
REQ-017 Output transfer on i without input transfer to i: out_valid[i] clears next cycle.
REQ-018 Simultaneous output transfer on i and input transfer to i: out_valid[i] stays 1 and out_data<i> takes the new word (full throughput, no bubble).
REQ-019 Channels not addressed by s SHALL be unaffected by the input side; each drains independently via its own out_ready.
REQ-020 out_data<i> SHALL hold its value while out_valid[i]=1 and out_ready[i]=0 (stall).
REQ-021 s MAY change every cycle; only the value of s in the accepting cycle determines routing.
REQ-022 in_valid=0 SHALL never modify any channel register, regardless of s.
REQ-023 No combinational path SHALL exist from in_valid or in_data to any output; only in_ready depends combinationally on s and out_ready.

Reset
REQ-024 On rst=1 at a clock edge: out_valid=4'b0000, out_data0..3=0, cnt0..3=0.
REQ-025 rst SHALL override any simultaneous input or output transfer; words held mid-operation are discarded.
REQ-026 While rst=1, in_ready SHALL follow REQ-014 using the reset-cleared state (i.e. 1 after the first reset edge).

Configuration
REQ-027 Macro STREAM_DEMUX_CNT_EN SHALL gate the transfer counters.
REQ-028 With STREAM_DEMUX_CNT_EN defined: cnt<i> increments by 1 on each input transfer to channel i, wraps 255->0, and cnt_clr=1 zeroes all counters, taking priority over a same-cycle increment.
REQ-029 Without STREAM_DEMUX_CNT_EN: cnt_clr and cnt0..cnt3 ports are absent; all other behaviour is identical.

Verification
REQ-030 Reset, then s=2, in_data=8'hA5, in_valid=1 for one cycle, out_ready=0 -> next cycle out_valid=4'b0100, out_data2=8'hA5; other out_valid bits stay 0.
REQ-031 Channel 1 full (out_valid[1]=1, out_ready[1]=0), s=1, in_valid=1 -> in_ready=0, out_data1 unchanged; raise out_ready[1] -> in_ready=1, new word replaces old next cycle, out_valid[1] stays 1.
REQ-032 Channel 0 full and stalled, s=3, in_valid=1 -> in_ready=1, word lands in channel 3; channel 0 data unchanged.
REQ-033 out_ready=4'b1111, in_valid=1, s cycling 0,1,2,3 for 8 cycles with data 1..8 -> one word per cycle emerges on the matching channel 1 cycle later, no drops.
REQ-034 Channel 2 valid, rst=1 coincident with an input transfer to channel 2 -> next cycle out_valid=4'b0000, out_data2=0.
REQ-035 (STREAM_DEMUX_CNT_EN) 256 transfers to channel 0 -> cnt0=0 after wrap; cnt_clr=1 coincident with a transfer -> cnt0=0 next cycle.
